// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and a small op-decode helper.
package mul_div_unit_pkg;

    localparam int MULDIV_OP_WIDTH = 3;

    localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_MULT  = 3'd0;
    localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_MULTU = 3'd1;
    localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_DIV   = 3'd2;
    localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_DIVU  = 3'd3;
    localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_MTHI  = 3'd4;
    localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_RUN  = 2'd1,
        MDS_FIX  = 2'd2
    } mds_state_e;

    function automatic logic is_div_op(input logic [MULDIV_OP_WIDTH-1:0] op);
        return (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 shift-add multiply on {acc, sreg}
// or one restoring-division step (remainder in acc, quotient shifted into sreg).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] sreg,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] sreg_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The remainder stays below the divisor, so diff's top bit is a clean borrow flag.
    always_comb begin
        sum     = {1'b0, acc} + (sreg[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        shifted = {acc, sreg[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        if (mode_div) begin
            if (!diff[WIDTH]) begin
                acc_next  = diff[WIDTH-1:0];
                sreg_next = {sreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next  = shifted[WIDTH-1:0];
                sreg_next = {sreg[WIDTH-2:0], 1'b0};
            end
        end else begin
            {acc_next, sreg_next} = {sum, sreg[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with private HI/LO registers.
// Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise they act as MULTU/DIVU.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [MULDIV_OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic                       div_by_zero,
    output logic [WIDTH-1:0]           hi,
    output logic [WIDTH-1:0]           lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mds_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] operand;
    logic             is_div;
    logic             dbz;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] sreg_nxt;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             accept;
    logic             op_div;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign start_ready = (state == MDS_IDLE);
    assign busy        = (state == MDS_RUN) || (state == MDS_FIX);
    assign accept      = start_valid && start_ready && !flush;
    assign op_div      = is_div_op(op);

`ifdef MULDIV_SIGNED_EN
    logic op_signed;
    logic sign_a;
    logic sign_b;
    logic neg_res;
    logic neg_rem;

    assign op_signed = (op == MULDIV_OP_MULT) || (op == MULDIV_OP_DIV);
    assign sign_a    = op_signed && a[WIDTH-1];
    assign sign_b    = op_signed && b[WIDTH-1];
    assign mag_a     = sign_a ? -a : a;
    assign mag_b     = sign_b ? -b : b;
`else
    assign mag_a = a;
    assign mag_b = b;
`endif

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mode_div (is_div),
        .acc      (acc),
        .sreg     (sreg),
        .operand  (operand),
        .acc_next (acc_nxt),
        .sreg_next(sreg_nxt)
    );

    // Both operations leave the high half / remainder in acc and the low half / quotient in sreg.
    always_comb begin
        res_hi = acc;
        res_lo = sreg;
`ifdef MULDIV_SIGNED_EN
        if (is_div) begin
            if (neg_res) res_lo = -sreg;
            if (neg_rem) res_hi = -acc;
        end else if (neg_res) begin
            {res_hi, res_lo} = -{acc, sreg};
        end
`endif
        if (dbz) begin
            res_hi = sreg;
            res_lo = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MDS_IDLE;
            cnt         <= '0;
            acc         <= '0;
            sreg        <= '0;
            operand     <= '0;
            is_div      <= 1'b0;
            dbz         <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
`endif
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                MDS_IDLE: begin
                    if (accept) begin
                        case (op)
                            MULDIV_OP_MTHI: hi <= a;
                            MULDIV_OP_MTLO: lo <= a;
                            MULDIV_OP_MULT, MULDIV_OP_MULTU,
                            MULDIV_OP_DIV,  MULDIV_OP_DIVU: begin
                                is_div  <= op_div;
                                acc     <= '0;
                                cnt     <= '0;
                                operand <= mag_b;
`ifdef MULDIV_SIGNED_EN
                                neg_res <= sign_a ^ sign_b;
                                neg_rem <= sign_a;
`endif
                                // Divide by zero skips RUN; raw a is parked in sreg for HI.
                                if (op_div && (b == '0)) begin
                                    dbz   <= 1'b1;
                                    sreg  <= a;
                                    state <= MDS_FIX;
                                end else begin
                                    dbz   <= 1'b0;
                                    sreg  <= mag_a;
                                    state <= MDS_RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                MDS_RUN: begin
                    if (flush) begin
                        state <= MDS_IDLE;
                    end else begin
                        acc  <= acc_nxt;
                        sreg <= sreg_nxt;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST) state <= MDS_FIX;
                    end
                end
                MDS_FIX: begin
                    state <= MDS_IDLE;
                    if (!flush) begin
                        hi          <= res_hi;
                        lo          <= res_lo;
                        done        <= 1'b1;
                        div_by_zero <= dbz;
                    end
                end
                default: state <= MDS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO/latency,
// a negedge monitor pops and compares on every done pulse.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int WIDTH = 32;

`ifdef MULDIV_SIGNED_EN
    localparam logic [31:0] T2_HI  = 32'hFFFFFFFF, T2_LO  = 32'hFFFFFFF1;
    localparam logic [31:0] T3_HI  = 32'hFFFFFFFF, T3_LO  = 32'hFFFFFFFD;
    localparam logic [31:0] T3B_HI = 32'h00000001, T3B_LO = 32'hFFFFFFFD;
    localparam logic [31:0] TM_HI  = 32'h00000000, TM_LO  = 32'h00000018;
    localparam logic [31:0] T4B_HI = 32'h00000000, T4B_LO = 32'h80000000;
`else
    localparam logic [31:0] T2_HI  = 32'h00000004, T2_LO  = 32'hFFFFFFF1;
    localparam logic [31:0] T3_HI  = 32'h00000001, T3_LO  = 32'h7FFFFFFC;
    localparam logic [31:0] T3B_HI = 32'h00000007, T3B_LO = 32'h00000000;
    localparam logic [31:0] TM_HI  = 32'hFFFFFFF6, TM_LO  = 32'h00000018;
    localparam logic [31:0] T4B_HI = 32'h80000000, T4B_LO = 32'h00000000;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        start_valid;
    logic        start_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks    = 0;
    int   passes    = 0;
    int   cyc       = 0;
    int   done_seen = 0;
    int   done_before;
    int   bc;
    bit   ok;

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Drives one offer right away (caller sits just after a negedge) and holds it for one edge.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] eh, input logic [31:0] el, input bit exp_done);
        exp_t e;
        bit   zdiv;
        op = o; a = av; b = bv; start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        zdiv = ((o == MULDIV_OP_DIV) || (o == MULDIV_OP_DIVU)) && (bv == 32'd0);
        if (exp_done) begin
            e.hi  = eh;
            e.lo  = el;
            e.dbz = zdiv;
            e.due = cyc + (zdiv ? 1 : WIDTH + 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic waitDone(input int max_cycles, output int busy_cnt, output bit seen);
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                return;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic runOp(input string name, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el);
        int r_bc;
        bit r_ok;
        int exp_busy;
        exp_busy = (((o == MULDIV_OP_DIV) || (o == MULDIV_OP_DIVU)) && (bv == 32'd0)) ? 1 : WIDTH + 1;
        @(negedge clk);
        applyStimulus(o, av, bv, eh, el, 1'b1);
        waitDone(WIDTH + 20, r_bc, r_ok);
        checkOutput({name, "_done_seen"}, 64'(r_ok), 64'd1);
        checkOutput({name, "_busy_cycles"}, 64'(r_bc), 64'(exp_busy));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done", 64'(done), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("sb_hi", 64'(hi), 64'(mon_e.hi));
                checkOutput("sb_lo", 64'(lo), 64'(mon_e.lo));
                checkOutput("sb_div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
                checkOutput("sb_latency", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; start_valid = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_ready", 64'(start_ready), 64'd1);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("multu_full", MULDIV_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

        // Signed multiply, then MTLO offered in the done cycle itself.
        @(negedge clk);
        applyStimulus(MULDIV_OP_MULT, -32'sd3, 32'd5, T2_HI, T2_LO, 1'b1);
        waitDone(WIDTH + 20, bc, ok);
        checkOutput("mult_done_seen", 64'(ok), 64'd1);
        checkOutput("ready_in_done_cycle", 64'(start_ready), 64'd1);
        applyStimulus(MULDIV_OP_MTLO, 32'h1234, 32'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("b2b_mtlo_lo", 64'(lo), 64'h1234);
        checkOutput("b2b_mtlo_hi_kept", 64'(hi), 64'(T2_HI));

        runOp("div_m7_2", MULDIV_OP_DIV, -32'sd7, 32'd2, T3_HI, T3_LO);
        runOp("div_7_m2", MULDIV_OP_DIV, 32'd7, -32'sd2, T3B_HI, T3B_LO);
        runOp("divu_100_7", MULDIV_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        runOp("mult_m4_m6", MULDIV_OP_MULT, -32'sd4, -32'sd6, TM_HI, TM_LO);
        runOp("divu_by_zero", MULDIV_OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
        runOp("div_neg_by_zero", MULDIV_OP_DIV, -32'sd5, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        runOp("div_min_m1", MULDIV_OP_DIV, 32'h80000000, 32'hFFFFFFFF, T4B_HI, T4B_LO);

        // Preload HI/LO, then flush a multiply in RUN cycle 10.
        @(negedge clk);
        applyStimulus(MULDIV_OP_MTHI, 32'hAA, 32'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("mthi_hi", 64'(hi), 64'hAA);
        @(negedge clk);
        applyStimulus(MULDIV_OP_MTLO, 32'h55, 32'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("mtlo_lo", 64'(lo), 64'h55);
        done_before = done_seen;
        @(negedge clk);
        applyStimulus(MULDIV_OP_MULTU, 32'd12345, 32'd678, 32'd0, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("run10_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_run_ready", 64'(start_ready), 64'd1);
        checkOutput("flush_run_busy", 64'(busy), 64'd0);
        checkOutput("flush_run_hi", 64'(hi), 64'hAA);
        checkOutput("flush_run_lo", 64'(lo), 64'h55);

        // Offers in IDLE coinciding with flush are ignored.
        @(negedge clk);
        op = MULDIV_OP_MTHI; a = 32'h77; start_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0; flush = 1'b0;
        checkOutput("flush_idle_mthi_hi", 64'(hi), 64'hAA);
        @(negedge clk);
        op = MULDIV_OP_MULTU; a = 32'd3; b = 32'd3; start_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0; flush = 1'b0;
        checkOutput("flush_idle_mult_busy", 64'(busy), 64'd0);

        // Flush arriving in FIX must still suppress the write.
        @(negedge clk);
        applyStimulus(MULDIV_OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0);
        repeat (WIDTH + 1) @(negedge clk);
        checkOutput("fix_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_fix_hi", 64'(hi), 64'hAA);
        checkOutput("flush_fix_lo", 64'(lo), 64'h55);
        checkOutput("flush_fix_ready", 64'(start_ready), 64'd1);
        repeat (WIDTH + 8) @(negedge clk);
        checkOutput("flush_no_done", 64'(done_seen), 64'(done_before));

        // Codes 6 and 7 are no-ops.
        @(negedge clk);
        applyStimulus(3'd6, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("nop_hi", 64'(hi), 64'hAA);
        checkOutput("nop_lo", 64'(lo), 64'h55);
        checkOutput("nop_busy", 64'(busy), 64'd0);

        // Asynchronous reset in RUN cycle 5.
        applyStimulus(MULDIV_OP_MULTU, 32'hFFFF, 32'hFFFF, 32'd0, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_run_hi", 64'(hi), 64'd0);
        checkOutput("rst_run_lo", 64'(lo), 64'd0);
        checkOutput("rst_run_busy", 64'(busy), 64'd0);
        checkOutput("rst_run_done", 64'(done), 64'd0);
        checkOutput("rst_run_ready", 64'(start_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("multu_6_7", MULDIV_OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
